// File: rtl/shift_pkg.sv
// Shared mode encoding for the shift_frame family of shifters.
package shift_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'b000,
    LOAD = 3'b001,
    SL   = 3'b010,
    SR   = 3'b011,
    ROL  = 3'b100,
    ROR  = 3'b101,
    ASR  = 3'b110,
    RSVD = 3'b111
  } shift_mode_e;

  // Modes that advance the frame counter.
  function automatic logic is_shift(input shift_mode_e m);
    return (m == SL) || (m == SR) || (m == ROL) || (m == ROR) || (m == ASR);
  endfunction

endpackage

// File: rtl/shift_frame_ctr.sv
// Wrap counter 0..FRAME-1 with terminal-count flag; count updates one clock after inc/clr.
// Stalls whenever inc is low; clr has priority over inc.
module shift_frame_ctr #(
  parameter int unsigned FRAME = 8,
  parameter int unsigned CNT_W = $clog2(FRAME + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  assign tc = (count == CNT_W'(FRAME - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/shift_frame.sv
// Universal multi-lane shift register with frame counter and optional auto-reload.
// All outputs registered (1-cycle latency); en_i low or HOLD freezes state and the frame.
module shift_frame
  import shift_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned LANES     = 1,
  localparam int unsigned FRAME    = BIT_WIDTH / LANES,
  localparam int unsigned CNT_W    = $clog2(FRAME + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [2:0]           mode_i,
  input  logic                 auto_reload_i,
  input  logic [BIT_WIDTH-1:0] parallel_i,
  input  logic [LANES-1:0]     serial_i,
  output logic [BIT_WIDTH-1:0] parallel_o,
  output logic [LANES-1:0]     serial_o,
  output logic                 frame_done_o,
  output logic [CNT_W-1:0]     count_o
);

  shift_mode_e          mode;
  logic [BIT_WIDTH-1:0] shifted;
  logic [LANES-1:0]     out_bits;
  logic                 do_shift;
  logic                 tc;

  assign mode     = shift_mode_e'(mode_i);
  assign do_shift = en_i && is_shift(mode);

  always_comb begin
    shifted  = parallel_o;
    out_bits = '0;
    case (mode)
      SL: begin
        shifted  = {parallel_o[BIT_WIDTH-LANES-1:0], serial_i};
        out_bits = parallel_o[BIT_WIDTH-1 -: LANES];
      end
      SR: begin
        shifted  = {serial_i, parallel_o[BIT_WIDTH-1:LANES]};
        out_bits = parallel_o[LANES-1:0];
      end
      ROL: begin
        shifted  = {parallel_o[BIT_WIDTH-LANES-1:0], parallel_o[BIT_WIDTH-1 -: LANES]};
        out_bits = parallel_o[BIT_WIDTH-1 -: LANES];
      end
      ROR: begin
        shifted  = {parallel_o[LANES-1:0], parallel_o[BIT_WIDTH-1:LANES]};
        out_bits = parallel_o[LANES-1:0];
      end
      ASR: begin
        shifted  = {{LANES{parallel_o[BIT_WIDTH-1]}}, parallel_o[BIT_WIDTH-1:LANES]};
        out_bits = parallel_o[LANES-1:0];
      end
      default: begin
        shifted  = parallel_o;
        out_bits = '0;
      end
    endcase
  end

  shift_frame_ctr #(
    .FRAME (FRAME),
    .CNT_W (CNT_W)
  ) u_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (en_i && (mode == LOAD)),
    .inc   (do_shift),
    .count (count_o),
    .tc    (tc)
  );

  // Final shift of a frame: serial_o still reports the shifted-out lanes even when reloading.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      parallel_o   <= '0;
      serial_o     <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (en_i && (mode == LOAD)) begin
        parallel_o <= parallel_i;
        serial_o   <= '0;
      end else if (do_shift) begin
        parallel_o   <= (tc && auto_reload_i) ? parallel_i : shifted;
        serial_o     <= out_bits;
        frame_done_o <= tc;
      end
    end
  end

endmodule
